// File: rtl/sc_gates_tester.sv
// rtl/sc_gates_tester.sv - self-test initiator that sweeps a two-input gate bank and checks its outputs
module sc_gates_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       SC_GATES_TESTER_CLOCK_50,
    input  logic       SC_GATES_TESTER_RESET_InHigh,
    input  logic       SC_GATES_TESTER_Start_InHigh,
    input  logic [7:0] SC_GATES_TESTER_Result_In,
    output logic       SC_GATES_TESTER_a_Out,
    output logic       SC_GATES_TESTER_b_Out,
    output logic       SC_GATES_TESTER_Busy_Out,
    output logic       SC_GATES_TESTER_Done_Out,
    output logic       SC_GATES_TESTER_Pass_Out,
    output logic [2:0] SC_GATES_TESTER_ErrCount_Out,
    output logic [7:0] SC_GATES_TESTER_FailMask_Out,
    output logic [1:0] SC_GATES_TESTER_FirstFail_Out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_err, w_err_nxt;
    logic [7:0] r_mask, w_mask_nxt;
    logic [1:0] r_first, w_first_nxt;
    logic       r_a, r_b, r_busy, r_done, r_pass;
    logic [7:0] w_expected;
    logic [7:0] w_mismatch;
    logic       w_running_nxt;

    // Known-good gate bank response for each a/b combination
    always_comb begin
        w_expected = 8'h00;
        case (r_idx)
            2'd0:    w_expected = 8'hC0;
            2'd1:    w_expected = 8'h7C;
            2'd2:    w_expected = 8'h7C;
            default: w_expected = 8'h07;
        endcase
    end

    assign w_mismatch = SC_GATES_TESTER_Result_In ^ w_expected;

    // Next-state and result update logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_mask_nxt  = r_mask;
        w_first_nxt = r_first;
        case (r_state)
            S_IDLE: begin
                if (SC_GATES_TESTER_Start_InHigh) begin
                    w_state_nxt = S_SETTLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_err_nxt   = 3'd0;
                    w_mask_nxt  = 8'h00;
                    w_first_nxt = 2'd0;
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // <= rather than == so a zero count can never lock the sweep up
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_mismatch != 8'h00) begin
                    w_err_nxt  = r_err + 3'd1;
                    w_mask_nxt = r_mask | w_mismatch;
                    // No earlier failure this run means this vector is the first
                    if (r_err == 3'd0) begin
                        w_first_nxt = r_idx;
                    end
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_cnt_nxt   = SETTLE_LOAD;
                end
            end
            default: begin
                if (!SC_GATES_TESTER_Start_InHigh) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign w_running_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CHECK);

    // State, result and registered output update with synchronous reset
    always_ff @(posedge SC_GATES_TESTER_CLOCK_50) begin
        if (SC_GATES_TESTER_RESET_InHigh) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_err   <= 3'd0;
            r_mask  <= 8'h00;
            r_first <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_mask  <= w_mask_nxt;
            r_first <= w_first_nxt;
            r_a     <= w_running_nxt & w_idx_nxt[1];
            r_b     <= w_running_nxt & w_idx_nxt[0];
            r_busy  <= w_running_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_pass  <= (w_state_nxt == S_DONE) && (w_err_nxt == 3'd0);
        end
    end

    assign SC_GATES_TESTER_a_Out         = r_a;
    assign SC_GATES_TESTER_b_Out         = r_b;
    assign SC_GATES_TESTER_Busy_Out      = r_busy;
    assign SC_GATES_TESTER_Done_Out      = r_done;
    assign SC_GATES_TESTER_Pass_Out      = r_pass;
    assign SC_GATES_TESTER_ErrCount_Out  = r_err;
    assign SC_GATES_TESTER_FailMask_Out  = r_mask;
    assign SC_GATES_TESTER_FirstFail_Out = r_first;

endmodule

// File: doc/sc_gates_tester.md
Name: sc_gates_tester

Overview:
- Sequential self-test initiator for the two-input gate bank: drives the bank's a/b inputs through all four input combinations and samples its eight gate outputs.
- Compares each sample against built-in expected values and reports pass/fail, error count, mismatch mask and first failing vector.
- Sits on the stimulus side of the gate bank as the initiator; the gate bank is the responder.
- Used on board, with results routed to LEDs, and in simulation benches.

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before sampling. Legal range 1..15; 4-bit counter.

Ports:
- SC_GATES_TESTER_CLOCK_50  in  1  system clock; all logic on rising edge.
- SC_GATES_TESTER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_GATES_TESTER_Start_InHigh  in  1  run request, level-sampled.
- SC_GATES_TESTER_Result_In  in  8  gate bank outputs, packed as:
  - bit0 and1, bit1 and2, bit2 or1, bit3 xor1
  - bit4 xor2, bit5 xor3, bit6 nand1, bit7 nor1
- SC_GATES_TESTER_a_Out  out  1  drives gate bank input a.
- SC_GATES_TESTER_b_Out  out  1  drives gate bank input b.
- SC_GATES_TESTER_Busy_Out  out  1  high while a run is in progress.
- SC_GATES_TESTER_Done_Out  out  1  high in the DONE state.
- SC_GATES_TESTER_Pass_Out  out  1  high in DONE when ErrCount==0.
- SC_GATES_TESTER_ErrCount_Out  out  3  number of failing vectors, 0..4.
- SC_GATES_TESTER_FailMask_Out  out  8  sticky OR of (Result_In XOR expected).
- SC_GATES_TESTER_FirstFail_Out  out  2  index of the first failing vector; 0 if none.

Behaviour:
- Reset: one clock with reset high forces the following, effective at that edge, including mid-run:
  - state IDLE
  - vector index 0, settle counter 0
  - every output 0
- Vector index idx (2 bits) maps to a_Out=idx[1], b_Out=idx[0]. Order: 00, 01, 10, 11.
- Expected results per idx:
  - idx0: 0xC0
  - idx1: 0x7C
  - idx2: 0x7C
  - idx3: 0x07
- a_Out/b_Out are registered and change only on state/idx updates.
- IDLE:
  - Busy=0, Done=0, a=b=0.
  - Result registers hold the previous run's values.
  - Start=1 sampled -> SETTLE with idx=0 and counter=SETTLE_CYCLES.
  - The same transition clears ErrCount, FailMask and FirstFail, and sets Busy=1.
- SETTLE:
  - Counter decrements each cycle.
  - When counter==1, next state is CHECK.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): Result_In is sampled at the edge ending CHECK, then:
  - mismatch = Result_In XOR expected(idx).
  - If mismatch != 0: ErrCount += 1, FailMask |= mismatch.
  - If this is the first failure of the run, FirstFail = idx.
  - If idx==3: next state DONE. Otherwise idx+1 and SETTLE with the counter reloaded.
- DONE:
  - Busy=0, Done=1, a=b=0.
  - Pass = (ErrCount==0).
  - Stays in DONE while Start=1, so a held Start does not retrigger.
  - Start=0 -> IDLE; Done and Pass drop, result registers are retained.
- Latency: with Start sampled at edge E, DONE is reached at edge E + 1 + 4*(SETTLE_CYCLES+1) - 1. For SETTLE_CYCLES=2, Done is high after edge E+12.
- Start during SETTLE/CHECK is ignored.
- ErrCount saturates naturally at 4; no overflow is possible in 3 bits.
- Result_In is treated as asynchronous to the vector change only within the settle window. No synchronizer; the source is on the same clock domain.

Test Plan:
- Reset: hold reset 3 cycles with random Start/Result_In -> all outputs 0, state IDLE; release -> outputs still 0.
- Golden run, SETTLE_CYCLES=2, Result_In driven by a correct gate bank:
  - 1-cycle Start pulse -> a/b = 00, 01, 10, 11, each held 3 cycles.
  - Busy high for 12 cycles; Done=1 after edge E+12.
  - Pass=1, ErrCount=0, FailMask=0x00, FirstFail=0.
- Stuck nand (Result_In bit6 forced 0) -> vectors 0, 1, 2 fail:
  - ErrCount=3, FailMask=0x40, FirstFail=0, Pass=0.
- Constant Result_In=0x7C -> vectors 0 and 3 fail:
  - ErrCount=2, FailMask=0xFF, FirstFail=0, Pass=0.
- Handshake:
  - Start held high through DONE -> stays DONE, no second run.
  - Start low -> IDLE next edge, ErrCount/FailMask retained.
  - New Start -> results cleared on the run-entry edge.
- Reset mid-run: assert reset during SETTLE of vector 2 -> next edge IDLE, a=b=0, all outputs 0. A Start pulse while Busy=1 (separate run) has no effect on sequence timing.
